// File: rtl/includes.sv
// ============================================================================
// Module      : includes (package)
// Description : Shared types, AXI constants and strobe helper for the
//               SRAM-like to AXI3 bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package includes;

    localparam int W_ADDR = 32;
    localparam int W_DATA = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        AW   = 3'd3,
        B    = 3'd4
    } axi_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_ID_INST    = 4'd0;
    localparam logic [3:0] AXI_ID_DATA    = 4'd1;

    // Byte-lane enables for a single beat; the master has already aligned wdata.
    function automatic logic [3:0] wstrb_of(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] strb;
        case (size)
            2'd0:    strb = 4'b0001 << addr_lo;
            2'd1:    strb = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_like_axi_bridge.sv
// ============================================================================
// Module      : sram_like_axi_bridge
// Description : Arbitrates the instruction/data SRAM-like ports (data wins)
//               onto one AXI3 master, one single-beat transaction at a time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_like_axi_bridge
    import includes::*;
(
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req,
    input  logic              i_wr,
    input  logic [1:0]        i_size,
    input  logic [W_ADDR-1:0] i_addr,
    input  logic [W_DATA-1:0] i_wdata,
    output logic [W_DATA-1:0] i_rdata,
    output logic              i_addr_ok,
    output logic              i_data_ok,

    input  logic              d_req,
    input  logic              d_wr,
    input  logic [1:0]        d_size,
    input  logic [W_ADDR-1:0] d_addr,
    input  logic [W_DATA-1:0] d_wdata,
    output logic [W_DATA-1:0] d_rdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,

    output logic [3:0]        arid,
    output logic [W_ADDR-1:0] araddr,
    output logic [3:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [1:0]        arlock,
    output logic [3:0]        arcache,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,

    input  logic [3:0]        rid,
    input  logic [W_DATA-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,

    output logic [3:0]        awid,
    output logic [W_ADDR-1:0] awaddr,
    output logic [3:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic [1:0]        awlock,
    output logic [3:0]        awcache,
    output logic [2:0]        awprot,
    output logic              awvalid,
    input  logic              awready,

    output logic [3:0]        wid,
    output logic [W_DATA-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,

    input  logic [3:0]        bid,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    axi_state_t        r_state;
    axi_state_t        w_next;

    logic              r_owner_d;
    logic [W_ADDR-1:0] r_addr;
    logic [1:0]        r_size;
    logic [W_DATA-1:0] r_wdata;
    logic              r_aw_done;
    logic              r_w_done;
    logic [W_DATA-1:0] r_i_rdata;
    logic [W_DATA-1:0] r_d_rdata;

    logic              w_grant_d;
    logic              w_grant_i;
    logic              w_aw_fin;
    logic              w_w_fin;
    logic              w_r_fire;
    logic              w_b_fire;
    logic              w_unused;

    // Response ID/status/last carry no information with a single outstanding beat.
    assign w_unused = ^{rid, rresp, rlast, bid, bresp};

    assign w_grant_d = (r_state == IDLE) && d_req && !rst;
    assign w_grant_i = (r_state == IDLE) && !d_req && i_req && !rst;
    assign w_aw_fin  = r_aw_done || awready;
    assign w_w_fin   = r_w_done  || wready;
    // Completion is masked during reset so an abandoned transfer never reports done.
    assign w_r_fire  = (r_state == R) && rvalid && !rst;
    assign w_b_fire  = (r_state == B) && bvalid && !rst;

    // ------------------------------------------------------------------ state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------- next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_next = d_wr ? AW : AR;
                end else if (w_grant_i) begin
                    w_next = i_wr ? AW : AR;
                end
            end
            AR:      if (arready) w_next = R;
            R:       if (rvalid)  w_next = IDLE;
            AW:      if (w_aw_fin && w_w_fin) w_next = B;
            B:       if (bvalid)  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        arvalid   = (r_state == AR);
        rready    = (r_state == R);
        awvalid   = (r_state == AW) && !r_aw_done;
        wvalid    = (r_state == AW) && !r_w_done;
        bready    = (r_state == B);
        i_addr_ok = w_grant_i;
        d_addr_ok = w_grant_d;
        i_data_ok = (w_r_fire || w_b_fire) && !r_owner_d;
        d_data_ok = (w_r_fire || w_b_fire) &&  r_owner_d;
        i_rdata   = (w_r_fire && !r_owner_d) ? rdata : r_i_rdata;
        d_rdata   = (w_r_fire &&  r_owner_d) ? rdata : r_d_rdata;
    end

    // ------------------------------------------------------- request capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner_d <= 1'b0;
            r_addr    <= '0;
            r_size    <= 2'd0;
            r_wdata   <= '0;
        end else if (w_grant_d) begin
            r_owner_d <= 1'b1;
            r_addr    <= d_addr;
            r_size    <= d_size;
            r_wdata   <= d_wdata;
        end else if (w_grant_i) begin
            r_owner_d <= 1'b0;
            r_addr    <= i_addr;
            r_size    <= i_size;
            r_wdata   <= i_wdata;
        end
    end

    // AW and W handshake independently; the flags remember which already happened.
    always_ff @(posedge clk) begin
        if (rst || (r_state != AW) || (w_aw_fin && w_w_fin)) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (awready) r_aw_done <= 1'b1;
            if (wready)  r_w_done  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else if (w_r_fire) begin
            if (r_owner_d) r_d_rdata <= rdata;
            else           r_i_rdata <= rdata;
        end
    end

    // ------------------------------------------------------------- AXI fields
    assign arid    = r_owner_d ? AXI_ID_DATA : AXI_ID_INST;
    assign araddr  = r_addr;
    assign arlen   = 4'd0;
    assign arsize  = {1'b0, r_size};
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

    assign awid    = arid;
    assign awaddr  = r_addr;
    assign awlen   = 4'd0;
    assign awsize  = {1'b0, r_size};
    assign awburst = AXI_BURST_INCR;
    assign awlock  = 2'd0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;

    assign wid     = awid;
    assign wdata   = r_wdata;
    assign wstrb   = wstrb_of(r_size, r_addr[1:0]);
    assign wlast   = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_sram_like_axi_bridge.sv
// ============================================================================
// Module      : tb_sram_like_axi_bridge
// Description : Self-checking bench: directed protocol scenarios plus a
//               randomized run against a byte-lane memory reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_like_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_wr, d_req, d_wr;
    logic [1:0]  i_size, d_size;
    logic [31:0] i_addr, i_wdata, i_rdata, d_addr, d_wdata, d_rdata;
    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic [3:0]  arid, arlen, arcache, rid, awid, awlen, awcache, wid, wstrb, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, rresp, awburst, awlock, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_like_axi_bridge dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        i_req = 0; i_wr = 0; i_size = 0; i_addr = 0; i_wdata = 0;
        d_req = 0; d_wr = 0; d_size = 0; d_addr = 0; d_wdata = 0;
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
        rid = 0; rdata = 0; rresp = 0; rlast = 1; bid = 0; bresp = 0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin
            failures++; $display("FAIL reset_valids got=%b want=00000", {arvalid, awvalid, wvalid, rready, bready});
        end
        checks++;
        if ({i_addr_ok, i_data_ok, d_addr_ok, d_data_ok} !== 4'b0) begin
            failures++; $display("FAIL reset_oks got=%b want=0000", {i_addr_ok, i_data_ok, d_addr_ok, d_data_ok});
        end
        checks++;
        if (i_rdata !== 32'h0 || d_rdata !== 32'h0 || araddr !== 32'h0 || wdata !== 32'h0) begin
            failures++; $display("FAIL reset_data got i=%h d=%h a=%h w=%h want=0", i_rdata, d_rdata, araddr, wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (arvalid !== 1'b0 || awvalid !== 1'b0) begin
            failures++; $display("FAIL reset_release got ar=%b aw=%b want=0", arvalid, awvalid);
        end
    endtask

    task automatic test_read_latency();
        @(negedge clk);
        arready = 1; rvalid = 1; rdata = 32'hDEADBEEF;
        d_req = 1; d_wr = 0; d_size = 2; d_addr = 32'h1000;
        #1;
        checks++;
        if (d_addr_ok !== 1'b1 || i_addr_ok !== 1'b0 || arvalid !== 1'b0) begin
            failures++; $display("FAIL rd_cycle0 got dok=%b iok=%b arv=%b want 1 0 0", d_addr_ok, i_addr_ok, arvalid);
        end
        @(negedge clk);
        d_req = 0;
        #1;
        checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h1000 || arid !== 4'd1 || arsize !== 3'd2 ||
            arlen !== 4'd0 || arburst !== 2'b01 || d_data_ok !== 1'b0) begin
            failures++; $display("FAIL rd_cycle1 got arv=%b addr=%h id=%0d size=%0d len=%0d burst=%b dok=%b",
                                 arvalid, araddr, arid, arsize, arlen, arburst, d_data_ok);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rready !== 1'b1 || d_data_ok !== 1'b1 || d_rdata !== 32'hDEADBEEF || i_data_ok !== 1'b0) begin
            failures++; $display("FAIL rd_cycle2 got rr=%b dok=%b rdata=%h iok=%b want 1 1 deadbeef 0",
                                 rready, d_data_ok, d_rdata, i_data_ok);
        end
        @(negedge clk);
        rvalid = 0; arready = 0; rdata = 32'h0;
        #1;
        checks++;
        if (d_data_ok !== 1'b0 || d_rdata !== 32'hDEADBEEF || i_rdata !== 32'h0 || arvalid !== 1'b0) begin
            failures++; $display("FAIL rd_hold got dok=%b d_rdata=%h i_rdata=%h arv=%b", d_data_ok, d_rdata, i_rdata, arvalid);
        end
    endtask

    task automatic test_priority();
        @(negedge clk);
        arready = 1; rvalid = 1; rdata = 32'h12345678;
        d_req = 1; d_wr = 0; d_size = 2; d_addr = 32'h3000;
        i_req = 1; i_wr = 0; i_size = 2; i_addr = 32'h4000;
        #1;
        checks++;
        if (d_addr_ok !== 1'b1 || i_addr_ok !== 1'b0) begin
            failures++; $display("FAIL prio_grant got d=%b i=%b want 1 0", d_addr_ok, i_addr_ok);
        end
        @(negedge clk);
        d_req = 0;
        #1;
        checks++;
        if (arid !== 4'd1 || araddr !== 32'h3000 || i_addr_ok !== 1'b0) begin
            failures++; $display("FAIL prio_d_ar got id=%0d addr=%h iok=%b want 1 3000 0", arid, araddr, i_addr_ok);
        end
        @(negedge clk);
        #1;
        checks++;
        if (d_data_ok !== 1'b1 || i_addr_ok !== 1'b0) begin
            failures++; $display("FAIL prio_d_done got dok=%b iok=%b want 1 0", d_data_ok, i_addr_ok);
        end
        @(negedge clk);
        #1;
        checks++;
        if (i_addr_ok !== 1'b1) begin
            failures++; $display("FAIL prio_i_grant got=%b want=1", i_addr_ok);
        end
        @(negedge clk);
        i_req = 0;
        #1;
        checks++;
        if (arvalid !== 1'b1 || arid !== 4'd0 || araddr !== 32'h4000) begin
            failures++; $display("FAIL prio_i_ar got arv=%b id=%0d addr=%h want 1 0 4000", arvalid, arid, araddr);
        end
        @(negedge clk);
        #1;
        checks++;
        if (i_data_ok !== 1'b1 || i_rdata !== 32'h12345678 || d_data_ok !== 1'b0) begin
            failures++; $display("FAIL prio_i_done got iok=%b rdata=%h dok=%b", i_data_ok, i_rdata, d_data_ok);
        end
        @(negedge clk);
        rvalid = 0; arready = 0;
    endtask

    task automatic test_write_strobe();
        logic [31:0] t_addr [2];
        logic [1:0]  t_size [2];
        logic [31:0] t_data [2];
        logic [3:0]  t_strb [2];
        t_addr[0] = 32'h2003; t_size[0] = 2'd0; t_data[0] = 32'h11000000; t_strb[0] = 4'b1000;
        t_addr[1] = 32'h2002; t_size[1] = 2'd1; t_data[1] = 32'hBEEF0000; t_strb[1] = 4'b1100;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            awready = 1; wready = 1; bvalid = 1;
            d_req = 1; d_wr = 1; d_size = t_size[k]; d_addr = t_addr[k]; d_wdata = t_data[k];
            #1;
            checks++;
            if (d_addr_ok !== 1'b1) begin
                failures++; $display("FAIL wr%0d_grant got=%b want=1", k, d_addr_ok);
            end
            @(negedge clk);
            d_req = 0;
            #1;
            checks++;
            if (awvalid !== 1'b1 || wvalid !== 1'b1 || awaddr !== t_addr[k] || awsize !== {1'b0, t_size[k]} ||
                wstrb !== t_strb[k] || wdata !== t_data[k] || awid !== 4'd1 || wid !== 4'd1 ||
                wlast !== 1'b1 || awburst !== 2'b01 || awlen !== 4'd0) begin
                failures++; $display("FAIL wr%0d_aw got awv=%b wv=%b addr=%h size=%0d strb=%b data=%h id=%0d wid=%0d want addr=%h strb=%b",
                                     k, awvalid, wvalid, awaddr, awsize, wstrb, wdata, awid, wid, t_addr[k], t_strb[k]);
            end
            @(negedge clk);
            #1;
            checks++;
            if (bready !== 1'b1 || d_data_ok !== 1'b1 || awvalid !== 1'b0) begin
                failures++; $display("FAIL wr%0d_b got br=%b dok=%b awv=%b want 1 1 0", k, bready, d_data_ok, awvalid);
            end
            @(negedge clk);
            bvalid = 0; awready = 0; wready = 0;
        end
    endtask

    task automatic test_aw_delay();
        int aw_cnt = 0;
        int w_cnt  = 0;
        @(negedge clk);
        awready = 0; wready = 1; bvalid = 0;
        d_req = 1; d_wr = 1; d_size = 2; d_addr = 32'h5000; d_wdata = 32'hCAFEF00D;
        #1;
        checks++;
        if (d_addr_ok !== 1'b1) begin
            failures++; $display("FAIL awd_grant got=%b want=1", d_addr_ok);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            d_req = 0;
            awready = (c == 3);
            #1;
            if (awvalid) aw_cnt++;
            if (wvalid)  w_cnt++;
        end
        checks++;
        if (aw_cnt != 4 || w_cnt != 1) begin
            failures++; $display("FAIL awd_counts got aw=%0d w=%0d want aw=4 w=1", aw_cnt, w_cnt);
        end
        @(negedge clk);
        awready = 0; wready = 0;
        #1;
        checks++;
        if (bready !== 1'b1 || d_data_ok !== 1'b0 || awvalid !== 1'b0 || wvalid !== 1'b0) begin
            failures++; $display("FAIL awd_b_wait got br=%b dok=%b awv=%b wv=%b want 1 0 0 0", bready, d_data_ok, awvalid, wvalid);
        end
        @(negedge clk);
        bvalid = 1;
        #1;
        checks++;
        if (d_data_ok !== 1'b1) begin
            failures++; $display("FAIL awd_done got=%b want=1", d_data_ok);
        end
        @(negedge clk);
        bvalid = 0;
    endtask

    task automatic test_ar_stall();
        @(negedge clk);
        arready = 0; rvalid = 0;
        i_req = 1; i_wr = 0; i_size = 2; i_addr = 32'h6004;
        #1;
        checks++;
        if (i_addr_ok !== 1'b1) begin
            failures++; $display("FAIL stall_grant got=%b want=1", i_addr_ok);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            i_req = 0;
            d_req = 1; d_wr = 0; d_size = 2; d_addr = 32'h6100;
            #1;
            checks++;
            if (arvalid !== 1'b1 || araddr !== 32'h6004 || arid !== 4'd0 || d_addr_ok !== 1'b0 || i_addr_ok !== 1'b0) begin
                failures++; $display("FAIL stall_c%0d got arv=%b addr=%h id=%0d dok=%b iok=%b", c, arvalid, araddr, arid, d_addr_ok, i_addr_ok);
            end
        end
        @(negedge clk);
        arready = 1;
        @(negedge clk);
        arready = 0; rvalid = 1; rdata = 32'h0BADF00D;
        #1;
        checks++;
        if (i_data_ok !== 1'b1 || i_rdata !== 32'h0BADF00D || d_addr_ok !== 1'b0) begin
            failures++; $display("FAIL stall_done got iok=%b rdata=%h dok=%b want 1 0badf00d 0", i_data_ok, i_rdata, d_addr_ok);
        end
        @(negedge clk);
        rvalid = 0;
        #1;
        checks++;
        if (d_addr_ok !== 1'b1) begin
            failures++; $display("FAIL stall_next_grant got=%b want=1", d_addr_ok);
        end
        @(negedge clk);
        d_req = 0; arready = 1; rvalid = 1; rdata = 32'h600D600D;
        @(negedge clk);
        #1;
        checks++;
        if (d_data_ok !== 1'b1 || d_rdata !== 32'h600D600D) begin
            failures++; $display("FAIL stall_next_done got dok=%b rdata=%h want 1 600d600d", d_data_ok, d_rdata);
        end
        @(negedge clk);
        arready = 0; rvalid = 0;
    endtask

    task automatic test_reset_in_r();
        @(negedge clk);
        arready = 1; rvalid = 0;
        d_req = 1; d_wr = 0; d_size = 2; d_addr = 32'h7000;
        @(negedge clk);
        d_req = 0;
        @(negedge clk);
        arready = 0;
        #1;
        checks++;
        if (rready !== 1'b1) begin
            failures++; $display("FAIL rstr_in_r got rready=%b want=1", rready);
        end
        @(negedge clk);
        rst = 1; rvalid = 1; rdata = 32'hAAAA5555;
        #1;
        checks++;
        if (d_data_ok !== 1'b0 || i_data_ok !== 1'b0) begin
            failures++; $display("FAIL rstr_during got dok=%b iok=%b want 0 0", d_data_ok, i_data_ok);
        end
        @(negedge clk);
        rst = 0; rvalid = 0;
        #1;
        checks++;
        if (rready !== 1'b0 || arvalid !== 1'b0 || d_data_ok !== 1'b0 || d_rdata !== 32'h0) begin
            failures++; $display("FAIL rstr_after got rr=%b arv=%b dok=%b rdata=%h want 0 0 0 0", rready, arvalid, d_data_ok, d_rdata);
        end
        @(negedge clk);
        arready = 1; rvalid = 1; rdata = 32'h00000055;
        d_req = 1; d_addr = 32'h7004;
        #1;
        checks++;
        if (d_addr_ok !== 1'b1) begin
            failures++; $display("FAIL rstr_regrant got=%b want=1", d_addr_ok);
        end
        @(negedge clk);
        d_req = 0;
        @(negedge clk);
        #1;
        checks++;
        if (d_data_ok !== 1'b1 || d_rdata !== 32'h00000055) begin
            failures++; $display("FAIL rstr_redone got dok=%b rdata=%h want 1 00000055", d_data_ok, d_rdata);
        end
        @(negedge clk);
        arready = 0; rvalid = 0;
    endtask

    // Randomized traffic on both ports against a random-latency slave; the
    // reference memory is updated from the size/address byte-lane rule.
    task automatic test_random();
        logic [31:0] smem [16];
        logic [31:0] mmem [16];
        bit          pend [2];
        bit          busy [2];
        logic        pwr  [2];
        logic [1:0]  psize[2];
        logic [31:0] paddr[2];
        logic [31:0] pwdata[2];
        bit          ex_valid = 0;
        int          ex_port  = 0;
        logic        ex_wr    = 0;
        logic [1:0]  ex_size  = 0;
        logic [31:0] ex_addr  = 0;
        logic [31:0] ex_wdata = 0;
        bit          s_ar_pend = 0;
        logic [31:0] s_ar_addr = 0;
        bit          s_aw_got = 0, s_w_got = 0;
        logic [31:0] s_aw_addr = 0, s_w_data = 0;
        logic [3:0]  s_w_strb = 0;
        int          done_cnt = 0;
        int          first, nb;
        logic [3:0]  mask;

        for (int k = 0; k < 16; k++) begin
            smem[k] = $urandom;
            mmem[k] = smem[k];
        end
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; busy[p] = 0; pwr[p] = 0; psize[p] = 0; paddr[p] = 0; pwdata[p] = 0;
        end

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && !busy[p] && cyc < 2800 && $urandom_range(0, 3) == 0) begin
                    pend[p]   = 1;
                    pwr[p]    = $urandom_range(0, 1);
                    psize[p]  = 2'($urandom_range(0, 2));
                    paddr[p]  = 32'h8000 | (32'($urandom_range(0, 15)) << 2);
                    if (psize[p] == 2'd0) paddr[p][1:0] = 2'($urandom_range(0, 3));
                    if (psize[p] == 2'd1) paddr[p][1]   = 1'($urandom_range(0, 1));
                    pwdata[p] = $urandom;
                end
            end
            i_req = pend[0]; i_wr = pwr[0]; i_size = psize[0]; i_addr = paddr[0]; i_wdata = pwdata[0];
            d_req = pend[1]; d_wr = pwr[1]; d_size = psize[1]; d_addr = paddr[1]; d_wdata = pwdata[1];
            arready = 1'($urandom_range(0, 1));
            awready = 1'($urandom_range(0, 1));
            wready  = 1'($urandom_range(0, 1));
            rvalid  = s_ar_pend && ($urandom_range(0, 1) == 1);
            rdata   = rvalid ? smem[s_ar_addr[5:2]] : $urandom;
            bvalid  = s_aw_got && s_w_got && ($urandom_range(0, 1) == 1);
            #1;

            if ((i_addr_ok || d_addr_ok) && (i_data_ok || d_data_ok)) begin
                checks++; failures++;
                $display("FAIL rnd_ok_overlap cyc=%0d got addr_ok and data_ok together", cyc);
            end
            // Completions first: a grant may not coincide with one, so order is free.
            for (int p = 0; p < 2; p++) begin
                logic dok;
                logic [31:0] rd;
                dok = (p == 0) ? i_data_ok : d_data_ok;
                rd  = (p == 0) ? i_rdata   : d_rdata;
                if (dok) begin
                    checks++;
                    if (!ex_valid || ex_port != p) begin
                        failures++; $display("FAIL rnd_data_ok_port cyc=%0d got port=%0d want port=%0d valid=%0d", cyc, p, ex_port, ex_valid);
                    end else if (!ex_wr) begin
                        checks++;
                        if (rd !== mmem[ex_addr[5:2]]) begin
                            failures++; $display("FAIL rnd_rdata cyc=%0d addr=%h got=%h want=%h", cyc, ex_addr, rd, mmem[ex_addr[5:2]]);
                        end
                    end else begin
                        first = int'(ex_addr[1:0]);
                        nb    = 1 << ex_size;
                        for (int b = 0; b < 4; b++)
                            if (b >= first && b < first + nb)
                                mmem[ex_addr[5:2]][8*b +: 8] = ex_wdata[8*b +: 8];
                    end
                    ex_valid = 0;
                    busy[p]  = 0;
                    done_cnt++;
                end
            end
            if (i_addr_ok || d_addr_ok) begin
                int p;
                p = d_addr_ok ? 1 : 0;
                checks++;
                if (ex_valid || (i_addr_ok && d_addr_ok) || (i_addr_ok && d_req)) begin
                    failures++; $display("FAIL rnd_grant cyc=%0d got iok=%b dok=%b d_req=%b busy=%0d", cyc, i_addr_ok, d_addr_ok, d_req, ex_valid);
                end
                ex_valid = 1; ex_port = p; ex_wr = pwr[p]; ex_size = psize[p];
                ex_addr = paddr[p]; ex_wdata = pwdata[p];
                pend[p] = 0; busy[p] = 1;
            end
            if (arvalid && arready) begin
                checks++;
                if (!ex_valid || ex_wr || araddr !== ex_addr || arid !== 4'(ex_port) || arsize !== {1'b0, ex_size}) begin
                    failures++; $display("FAIL rnd_ar cyc=%0d got addr=%h id=%0d size=%0d want addr=%h id=%0d size=%0d",
                                         cyc, araddr, arid, arsize, ex_addr, ex_port, ex_size);
                end
                s_ar_pend = 1; s_ar_addr = araddr;
            end
            if (rvalid && rready) s_ar_pend = 0;
            if (awvalid && awready) begin
                checks++;
                if (!ex_valid || !ex_wr || awaddr !== ex_addr || awid !== 4'(ex_port) || awsize !== {1'b0, ex_size}) begin
                    failures++; $display("FAIL rnd_aw cyc=%0d got addr=%h id=%0d size=%0d want addr=%h id=%0d size=%0d",
                                         cyc, awaddr, awid, awsize, ex_addr, ex_port, ex_size);
                end
                s_aw_got = 1; s_aw_addr = awaddr;
            end
            if (wvalid && wready) begin
                first = int'(ex_addr[1:0]);
                nb    = 1 << ex_size;
                mask  = 4'b0;
                for (int b = 0; b < 4; b++)
                    if (b >= first && b < first + nb) mask[b] = 1'b1;
                checks++;
                if (wdata !== ex_wdata || wstrb !== mask || wid !== 4'(ex_port) || wlast !== 1'b1) begin
                    failures++; $display("FAIL rnd_w cyc=%0d got data=%h strb=%b wid=%0d want data=%h strb=%b wid=%0d",
                                         cyc, wdata, wstrb, wid, ex_wdata, mask, ex_port);
                end
                s_w_got = 1; s_w_data = wdata; s_w_strb = wstrb;
            end
            if (bvalid && bready) begin
                for (int b = 0; b < 4; b++)
                    if (s_w_strb[b]) smem[s_aw_addr[5:2]][8*b +: 8] = s_w_data[8*b +: 8];
                s_aw_got = 0; s_w_got = 0;
            end
        end

        checks++;
        if (ex_valid || pend[0] || pend[1] || done_cnt < 100) begin
            failures++; $display("FAIL rnd_drain got outstanding=%0d pend=%0d%0d completed=%0d want 0 00 >=100",
                                 ex_valid, pend[0], pend[1], done_cnt);
        end
        @(negedge clk);
        i_req = 0; d_req = 0; arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_priority();
        test_write_strobe();
        test_aw_delay();
        test_ar_stall();
        test_reset_in_r();
        test_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
